mux_sel_sequencer: RTL and testbench

//  Registered select generator sitting directly upstream of the 2-level mux tree.

---
 rtl/mux_sel_sequencer.sv | 143 ++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Registered select generator for a 2-level mux tree, y = ((s2 ? d : s1) ? b : a).
//   Arbitrates between req_a and req_b. A selection is held for at least
//   MIN_DWELL cycles, and each switch is followed by SETTLE_CYC cycles in which
//   y is not trusted. The returned y is captured into y_q while the path is
//   qualified.
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_a, req_b      per-source path requests
//   y_in              y fed back from the mux tree
//   s1, s2, d         registered selects to the tree
//   cur_sel           0 = a selected/targeted, 1 = b
//   out_valid         selects stable and settled
//   y_q, y_q_vld      captured y_in, and a flag that it was taken on a valid cycle
//   sw_cnt            completed switch count (wraps modulo 256)
module mux_sel_sequencer #(
  parameter int MIN_DWELL  = 4,
  parameter int SETTLE_CYC = 2,
  parameter int USE_D_PATH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       y_in,
  output logic       s1,
  output logic       s2,
  output logic       d,
  output logic       cur_sel,
  output logic       out_valid,
  output logic       y_q,
  output logic       y_q_vld,
  output logic [7:0] sw_cnt
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [DW-1:0] DWELL_MAX   = DW'(MIN_DWELL - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {SETTLE, SEL_A, SEL_B} state_t;

  // {s1, s2, d} for a given target; a is always the all-zero code.
  function automatic logic [2:0] enc(input logic to_b);
    if (!to_b)                return 3'b000;
    else if (USE_D_PATH != 0) return 3'b011;
    else                      return 3'b100;
  endfunction

  state_t          state_q, state_d;
  logic            tgt_q, tgt_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            pend_q, pend_d;   // a granted switch is in flight (count on completion)
  logic [2:0]      sel_q, sel_d;
  logic            ov_q, ov_d;
  logic [7:0]      sw_q, sw_d;
  logic            yq_q, yqv_q;
  logic            other_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      tgt_q    <= 1'b0;
      settle_q <= SETTLE_INIT;
      dwell_q  <= '0;
      pend_q   <= 1'b0;
      sel_q    <= 3'b000;
      ov_q     <= 1'b0;
      sw_q     <= 8'd0;
      yq_q     <= 1'b0;
      yqv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      pend_q   <= pend_d;
      sel_q    <= sel_d;
      ov_q     <= ov_d;
      sw_q     <= sw_d;
      // y is only trusted on cycles where the registered path is qualified
      if (ov_q) begin
        yq_q  <= y_in;
        yqv_q <= 1'b1;
      end else begin
        yqv_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    settle_d  = settle_q;
    dwell_d   = dwell_q;
    pend_d    = pend_q;
    sel_d     = sel_q;
    ov_d      = ov_q;
    sw_d      = sw_q;
    other_req = (state_q == SEL_B) ? req_a : req_b;
    case (state_q)
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = tgt_q ? SEL_B : SEL_A;
          dwell_d = '0;
          ov_d    = 1'b1;
          // the post-reset settle has no pending grant, so it is not counted
          if (pend_q) begin
            sw_d   = sw_q + 8'd1;
            pend_d = 1'b0;
          end
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      SEL_A, SEL_B: begin
        // own req is irrelevant: the other side wins after dwell -> round-robin
        if (dwell_q == DWELL_MAX) begin
          if (other_req) begin
            state_d  = SETTLE;
            tgt_d    = ~tgt_q;
            sel_d    = enc(~tgt_q);
            ov_d     = 1'b0;
            settle_d = SETTLE_INIT;
            pend_d   = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  assign {s1, s2, d} = sel_q;
  assign cur_sel     = tgt_q;
  assign out_valid   = ov_q;
  assign y_q         = yq_q;
  assign y_q_vld     = yqv_q;
  assign sw_cnt      = sw_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, y_in = 1'b0;

  logic       s1_o[2], s2_o[2], d_o[2], cs_o[2], ov_o[2], yq_o[2], yqv_o[2];
  logic [7:0] sw_o[2];

  int checks = 0;
  int failures = 0;
  int e = 0;

  always #5 clk = ~clk;

  // dut0: default parameters; dut1: tightest timing with the s1 encoding for b
  mux_sel_sequencer #(.MIN_DWELL(4), .SETTLE_CYC(2), .USE_D_PATH(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .y_in(y_in),
    .s1(s1_o[0]), .s2(s2_o[0]), .d(d_o[0]), .cur_sel(cs_o[0]), .out_valid(ov_o[0]),
    .y_q(yq_o[0]), .y_q_vld(yqv_o[0]), .sw_cnt(sw_o[0]));

  mux_sel_sequencer #(.MIN_DWELL(1), .SETTLE_CYC(1), .USE_D_PATH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .y_in(y_in),
    .s1(s1_o[1]), .s2(s2_o[1]), .d(d_o[1]), .cur_sel(cs_o[1]), .out_valid(ov_o[1]),
    .y_q(yq_o[1]), .y_q_vld(yqv_o[1]), .sw_cnt(sw_o[1]));

  function automatic int md(input int k);  return (k == 0) ? 4 : 1; endfunction
  function automatic int sc(input int k);  return (k == 0) ? 2 : 1; endfunction
  function automatic int udp(input int k); return (k == 0) ? 1 : 0; endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Behavioural model: time spent in the current selection and settle cycles
  // remaining, counted directly in cycles.
  bit m_b[2], m_set[2], m_pend[2], m_val[2], m_yq[2], m_yqv[2];
  int m_left[2], m_held[2], m_sw[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_b[k] <= 0; m_set[k] <= 1; m_left[k] <= sc(k); m_held[k] <= 0;
        m_pend[k] <= 0; m_val[k] <= 0; m_yq[k] <= 0; m_yqv[k] <= 0; m_sw[k] <= 0;
      end else begin
        if (m_val[k]) begin m_yq[k] <= y_in; m_yqv[k] <= 1; end
        else m_yqv[k] <= 0;
        if (m_set[k]) begin
          if (m_left[k] == 1) begin
            m_set[k] <= 0; m_held[k] <= 0; m_val[k] <= 1;
            if (m_pend[k]) begin m_sw[k] <= (m_sw[k] + 1) % 256; m_pend[k] <= 0; end
          end else m_left[k] <= m_left[k] - 1;
        end else if (m_held[k] + 1 >= md(k) && (m_b[k] ? req_a : req_b)) begin
          m_b[k] <= !m_b[k]; m_set[k] <= 1; m_left[k] <= sc(k);
          m_val[k] <= 0; m_pend[k] <= 1;
        end else m_held[k] <= m_held[k] + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int es1, es2, ed;
      es1 = (m_b[k] && udp(k) == 0) ? 1 : 0;
      es2 = (m_b[k] && udp(k) == 1) ? 1 : 0;
      ed  = es2;
      chk($sformatf("dut%0d.s1", k), s1_o[k], es1);
      chk($sformatf("dut%0d.s2", k), s2_o[k], es2);
      chk($sformatf("dut%0d.d", k), d_o[k], ed);
      chk($sformatf("dut%0d.route_b", k), ((s2_o[k] ? d_o[k] : s1_o[k]) ? 1 : 0), m_b[k]);
      chk($sformatf("dut%0d.cur_sel", k), cs_o[k], m_b[k]);
      chk($sformatf("dut%0d.out_valid", k), ov_o[k], m_val[k]);
      chk($sformatf("dut%0d.y_q", k), yq_o[k], m_yq[k]);
      chk($sformatf("dut%0d.y_q_vld", k), yqv_o[k], m_yqv[k]);
      chk($sformatf("dut%0d.sw_cnt", k), sw_o[k], m_sw[k]);
    end
  end

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (e < target) begin tick(); e++; end
  endtask

  task automatic do_reset(input logic ra, input logic rb);
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; y_in = 1'b0;
    tick(); tick();
    req_a = ra; req_b = rb;
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst.s1", s1_o[0], 0); chk("rst.s2", s2_o[0], 0); chk("rst.d", d_o[0], 0);
    chk("rst.out_valid", ov_o[0], 0); chk("rst.sw_cnt", sw_o[0], 0);
    chk("rst.y_q_vld", yqv_o[0], 0);

    // 1: release with no requests
    rst_n = 1'b1; e = 0;
    run_to(1); chk("t1.ov_e1", ov_o[0], 0); chk("t1.dut1_ov_e1", ov_o[1], 1);
    run_to(2); chk("t1.ov_e2", ov_o[0], 1); chk("t1.s2_e2", s2_o[0], 0);
    chk("t1.sw_e2", sw_o[0], 0);

    // 2: req_b held, grant after 4 SEL_A cycles
    req_b = 1'b1;
    run_to(5); chk("t2.cs_e5", cs_o[0], 0);
    run_to(6);
    chk("t2.s1", s1_o[0], 0); chk("t2.s2", s2_o[0], 1); chk("t2.d", d_o[0], 1);
    chk("t2.cs", cs_o[0], 1); chk("t2.ov_e6", ov_o[0], 0);
    run_to(7); chk("t2.ov_e7", ov_o[0], 0); chk("t2.yqv_e7", yqv_o[0], 0);
    run_to(8); chk("t2.ov_e8", ov_o[0], 1); chk("t2.sw_e8", sw_o[0], 1);
    // 5: s1 encoding on dut1, y capture
    chk("t5.dut1_s1", s1_o[1], 1); chk("t5.dut1_s2", s2_o[1], 0); chk("t5.dut1_d", d_o[1], 0);
    y_in = 1'b1;
    run_to(9); chk("t5.yq", yq_o[0], 1); chk("t5.yqv", yqv_o[0], 1);
    y_in = 1'b0;
    run_to(10); chk("t5.yq0", yq_o[0], 0);

    // 4: short pulse during dwell ignored, aligned pulse switches
    do_reset(1'b0, 1'b0);
    run_to(2); req_b = 1'b1;
    run_to(4); req_b = 1'b0;
    run_to(8); chk("t4.no_sw_cs", cs_o[0], 0); chk("t4.no_sw_cnt", sw_o[0], 0);
    req_b = 1'b1;
    run_to(9); req_b = 1'b0; chk("t4.sw_cs", cs_o[0], 1);
    run_to(14); req_a = 1'b1;
    run_to(15); req_a = 1'b0; chk("t4.aligned_cs", cs_o[0], 0);
    run_to(17); chk("t4.sw_cnt", sw_o[0], 2);

    // 6: reset during SETTLE toward b
    do_reset(1'b0, 1'b1);
    y_in = 1'b1;
    run_to(6); chk("t6.cs_pre", cs_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.s1", s1_o[0], 0); chk("t6.s2", s2_o[0], 0); chk("t6.d", d_o[0], 0);
    chk("t6.cs", cs_o[0], 0); chk("t6.ov", ov_o[0], 0); chk("t6.yq", yq_o[0], 0);
    chk("t6.yqv", yqv_o[0], 0); chk("t6.sw", sw_o[0], 0);
    @(negedge clk);
    req_b = 1'b0; y_in = 1'b0; rst_n = 1'b1; e = 0;
    run_to(3); chk("t6.sw_after", sw_o[0], 0); chk("t6.cs_after", cs_o[0], 0);
    chk("t6.ov_after", ov_o[0], 1);

    // 3 + 7: both requesting, alternation then wrap of sw_cnt
    do_reset(1'b1, 1'b1);
    run_to(6);  chk("t3.cs_e6", cs_o[0], 1);
    run_to(12); chk("t3.cs_e12", cs_o[0], 0);
    run_to(18); chk("t3.cs_e18", cs_o[0], 1);
    run_to(20); chk("t3.sw_e20", sw_o[0], 3);
    run_to(1535); chk("t7.dut1_sw_255", sw_o[1], 255);
    run_to(1537); chk("t7.sw_255", sw_o[0], 255); chk("t7.dut1_sw_wrap", sw_o[1], 0);
    run_to(1538); chk("t7.sw_wrap", sw_o[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
